// File: rtl/frame_loader_if.sv
// Pixel stream, CNN handshake and frame-memory read port of the frame loader.
interface frame_loader_if #(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_W    = 10
);
   // pixel stream
   logic                        in_valid;
   logic signed [DATA_SIZE-1:0] in_data;
   logic                        in_last;
   logic                        in_ready;
   // CNN side
   logic                        frame_start;
   logic                        cnn_done;
   logic [ADDR_W-1:0]           rd_addr;
   logic signed [DATA_SIZE-1:0] rd_data;
   // status
   logic                        frame_err;
   logic [15:0]                 frame_count;
   logic [7:0]                  err_count;

   // producer / CNN side
   modport master (
      output in_valid, in_data, in_last, cnn_done, rd_addr,
      input  in_ready, frame_start, rd_data, frame_err, frame_count, err_count
   );

   // frame loader side
   modport slave (
      input  in_valid, in_data, in_last, cnn_done, rd_addr,
      output in_ready, frame_start, rd_data, frame_err, frame_count, err_count
   );
endinterface

// File: rtl/frame_loader.sv
// Ping-pong input frame buffer: one bank fills from the pixel stream while the
// other is held read-only for the CNN. A completed frame swaps in as soon as the
// CNN bank is free, and frame_start launches inference on it.
// ADDR_W must satisfy 2**ADDR_W >= DATA_X*DATA_Y.
module frame_loader #(
   parameter int DATA_X    = 28,
   parameter int DATA_Y    = 28,
   parameter int DATA_SIZE = 32,
   parameter int ADDR_W    = 10
) (
   input  logic          clk,
   input  logic          rst,
   frame_loader_if.slave bus
);
   localparam int                NPIX     = DATA_X * DATA_Y;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
   localparam logic [ADDR_W:0]   NPIX_W   = (ADDR_W + 1)'(NPIX);

   // two frame banks; contents are deliberately left unreset
   logic [DATA_SIZE-1:0] mem [2][NPIX];

   logic                 wr_bank;      // bank being filled
   logic                 full_w;       // write bank holds a complete frame
   logic                 owned;        // CNN holds the read bank
   logic [ADDR_W-1:0]    wr_idx;
   logic                 frame_start_q;
   logic                 frame_err_q;
   logic [15:0]          frame_count_q;
   logic [7:0]           err_count_q;
   logic [DATA_SIZE-1:0] rd_data_q;

   logic rd_bank, accept, at_end, frame_done, bad_beat, wr_en, do_swap, in_range;

   assign rd_bank    = !wr_bank;
   // a finished write bank back-pressures the stream until it swaps
   assign accept     = bus.in_valid && !full_w;
   assign at_end     = (wr_idx == LAST_IDX);
   // a frame is good only when in_last lands exactly on the final pixel
   assign frame_done = accept && at_end && bus.in_last;
   assign bad_beat   = accept && (at_end != bus.in_last);
   assign wr_en      = accept && !bad_beat;
   // a pending frame swaps in once the CNN has released, or is releasing now
   assign do_swap    = full_w && (!owned || bus.cnn_done);
   assign in_range   = {1'b0, bus.rd_addr} < NPIX_W;

   assign bus.in_ready    = !full_w;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.frame_count = frame_count_q;
   assign bus.err_count   = err_count_q;
   assign bus.rd_data     = rd_data_q;

   // pixel write into the fill bank; only the fill bank is ever written
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_bank][wr_idx] <= bus.in_data;
   end

   // registered read from the CNN bank; out-of-frame addresses read as zero
   always_ff @(posedge clk) begin
      if (rst)           rd_data_q <= '0;
      else if (in_range) rd_data_q <= mem[rd_bank][bus.rd_addr];
      else               rd_data_q <= '0;
   end

   // bank swap / ownership tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank       <= 1'b0;
         owned         <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         frame_start_q <= 1'b0;
         if (do_swap) begin
            wr_bank       <= !wr_bank;
            owned         <= 1'b1;
            frame_start_q <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
         end else if (bus.cnn_done) begin
            // a release while not owned simply leaves owned clear
            owned <= 1'b0;
         end
      end
   end

   // write index, frame completion and malformed-frame handling; do_swap
   // needs full_w set and frame_done needs it clear, so they never collide
   always_ff @(posedge clk) begin
      if (rst) begin
         full_w      <= 1'b0;
         wr_idx      <= '0;
         frame_err_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         frame_err_q <= 1'b0;
         if (do_swap) full_w <= 1'b0;
         if (frame_done) begin
            full_w <= 1'b1;
            wr_idx <= '0;
         end else if (bad_beat) begin
            // drop the beat; the next one starts a fresh frame at pixel 0
            wr_idx      <= '0;
            frame_err_q <= 1'b1;
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
         end else if (accept) begin
            wr_idx <= wr_idx + ADDR_W'(1);
         end
      end
   end
endmodule
